// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock ratio meter.
package clk_meas_pkg;

  // Default width of the period / high-time counters (matches the divider mode width).
  localparam int CW_DEF = 31;

  // Width of the lock match counter; LOCK_CNT is limited to 1..15.
  localparam int LOCK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_e;

endpackage

// File: rtl/clk_ratio_meter_sig_edge_detect.sv
// Brings the asynchronous clock under test into the reference domain:
// a 2-flop synchronizer followed by one delay register for edge detection.
module sig_edge_detect (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic sig_in,
  output logic sig_sync,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Synchronizer chain plus the edge-detect delay stage.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this a true 3-stage shift register;
      // blocking ones would collapse it into a single flop.
      r_meta <= sig_in;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign sig_sync = r_sync;
  assign rise     = r_sync & ~r_dly;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures a divided clock against clk_100MHz: period, sampled high time and lock.
// Optional feature macro: DUTY_MEAS_EN builds the high-time counter; when it is
// undefined high_time is tied to 0 and period/lock behaviour is unchanged.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int          CW       = CW_DEF,
  parameter int          LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic          clk_100MHz,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]     CNT_MAX   = '1;
  localparam logic [CW-1:0]     TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_C    = LOCK_W'(LOCK_CNT);
  localparam logic [LOCK_W-1:0] MATCH_ONE = LOCK_W'(1);

  logic w_sig_sync;
  logic w_rise;

  meas_state_e r_state;
  meas_state_e w_state_d;
  logic        w_start;    // first rise seen in ARM
  logic        w_upd;      // rise in MEASURE: a full period is complete
  logic        w_tmo;      // no rise within TIMEOUT cycles

  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_period;
  logic [LOCK_W-1:0] r_match;
  logic              r_have_prev;
  logic              r_period_valid;
  logic              r_locked;
  logic              r_timeout;

  sig_edge_detect u_edge (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .sig_in     (sig_in),
    .sig_sync   (w_sig_sync),
    .rise       (w_rise)
  );

  // State register.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  // Next-state decode; a rise always wins over the timeout on the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_d = r_state;
    w_start   = 1'b0;
    w_upd     = 1'b0;
    w_tmo     = 1'b0;
    if (!en) begin
      w_state_d = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_d = ARM;
        ARM: begin
          if (w_rise) begin
            w_start   = 1'b1;
            w_state_d = MEASURE;
          end else if (r_cnt >= TIMEOUT_C) begin
            w_tmo = 1'b1;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_upd = 1'b1;
          end else if (r_cnt >= TIMEOUT_C) begin
            w_tmo     = 1'b1;
            w_state_d = ARM;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  // Period counter, period capture, lock tracking and sticky timeout.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_match        <= '0;
      r_have_prev    <= 1'b0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_period_valid <= w_upd;
      if (!en || r_state == IDLE) begin
        // Hold period and timeout; drop everything tied to the current run.
        r_cnt       <= '0;
        r_match     <= '0;
        r_have_prev <= 1'b0;
        r_locked    <= 1'b0;
      end else if (w_start) begin
        r_cnt       <= CNT_ONE;
        r_have_prev <= 1'b0;
        r_timeout   <= 1'b0;
      end else if (w_upd) begin
        r_period    <= r_cnt;
        r_cnt       <= CNT_ONE;
        r_have_prev <= 1'b1;
        r_timeout   <= 1'b0;
        // The first period after arming has nothing to be compared against.
        if (!r_have_prev || r_cnt != r_period) begin
          r_match  <= '0;
          r_locked <= 1'b0;
        end else if (r_match != LOCK_C) begin
          r_match <= r_match + MATCH_ONE;
          if ((r_match + MATCH_ONE) == LOCK_C) r_locked <= 1'b1;
        end
      end else if (w_tmo) begin
        r_timeout   <= 1'b1;
        r_locked    <= 1'b0;
        r_match     <= '0;
        r_have_prev <= 1'b0;
        r_cnt       <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_high_time;

  // High-time counter: the rise cycle counts as the first high cycle.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_high_time <= '0;
    end else if (!en || r_state == IDLE) begin
      r_hcnt <= '0;
    end else if (w_start || w_upd) begin
      if (w_upd) r_high_time <= r_hcnt;
      r_hcnt <= CNT_ONE;
    end else if (w_tmo) begin
      r_hcnt <= '0;
    end else if (w_sig_sync && r_hcnt != CNT_MAX) begin
      r_hcnt <= r_hcnt + CNT_ONE;
    end
  end

  assign high_time = r_high_time;
`else
  wire w_unused_sync = w_sig_sync;
  assign high_time = '0;
`endif

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: a synchronous pattern generator stands in
// for the clock divider; steady ratios are table driven, corner cases are scripted.
module tb_clk_ratio_meter;

  localparam int CW       = 31;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 100;
`ifdef DUTY_MEAS_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic          clk_100MHz;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  int checks   = 0;
  int failures = 0;

  // Pattern generator controls (new settings take effect at a period boundary).
  bit gen_on   = 1'b0;
  int gen_per  = 4;
  int gen_high = 2;
  int cur_per  = 4;
  int cur_high = 2;
  int ph       = 0;
  int gen_rises = 0;

  typedef struct {
    int per;
    int high;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[8];

  clk_ratio_meter #(
    .CW       (CW),
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Divider model: high for cur_high cycles, low for the rest of cur_per.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (!gen_on) begin
        sig_in = 1'b0;
        ph     = 0;
      end else begin
        if (ph == 0) begin
          cur_per  = gen_per;
          cur_high = gen_high;
        end
        if (!sig_in && ph < cur_high) gen_rises++;
        sig_in = (ph < cur_high);
        ph++;
        if (ph >= cur_per) ph = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100MHz);
      if (period_valid) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: no period_valid within %0d cycles", tag, budget);
  endtask

  // Reset with generator stopped; returns on a falling edge with rst low.
  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b0;
    gen_on = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    rst = 1'b0;
  endtask

  task automatic start_run(input int per, input int high);
    do_reset();
    en       = 1'b1;
    gen_per  = per;
    gen_high = high;
    repeat (3) @(negedge clk_100MHz);
    gen_on = 1'b1;
  endtask

  // Checks n consecutive strobes; locked is expected from strobe lock_at onward.
  task automatic run_strobes(input string tag, input int n, input int exp_p,
                             input int exp_h, input int lock_at);
    bit ok;
    for (int k = 1; k <= n; k++) begin
      wait_strobe(tag, 4 * exp_p + 12, ok);
      if (!ok) return;
      check($sformatf("%s_period_%0d", tag, k), 32'(period), exp_p);
      check($sformatf("%s_high_%0d", tag, k), 32'(high_time), DUTY ? exp_h : 0);
      check($sformatf("%s_locked_%0d", tag, k), {31'b0, locked}, (k >= lock_at) ? 1 : 0);
    end
  endtask

  initial begin
    bit ok;
    bit found;
    int n;
    int r0;

    vecs[0] = '{per: 4,  high: 2, exp_period: 4,  exp_high: 2};
    vecs[1] = '{per: 5,  high: 2, exp_period: 5,  exp_high: 2};
    vecs[2] = '{per: 5,  high: 3, exp_period: 5,  exp_high: 3};
    vecs[3] = '{per: 2,  high: 1, exp_period: 2,  exp_high: 1};
    vecs[4] = '{per: 3,  high: 2, exp_period: 3,  exp_high: 2};
    vecs[5] = '{per: 7,  high: 1, exp_period: 7,  exp_high: 1};
    vecs[6] = '{per: 10, high: 5, exp_period: 10, exp_high: 5};
    vecs[7] = '{per: 16, high: 9, exp_period: 16, exp_high: 9};

    // Reset state.
    rst = 1'b1;
    en  = 1'b0;
    #2;
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", {31'b0, period_valid}, 0);
    check("rst_locked", {31'b0, locked}, 0);
    check("rst_timeout", {31'b0, timeout}, 0);

    // Steady ratios: lock on the 6th rise after ARM, i.e. the 5th strobe.
    foreach (vecs[i]) begin
      start_run(vecs[i].per, vecs[i].high);
      run_strobes($sformatf("vec%0d", i), LOCK_CNT + 3, vecs[i].exp_period,
                  vecs[i].exp_high, LOCK_CNT + 1);
    end

    // Ratio change 4 -> 10 once locked.
    start_run(4, 2);
    run_strobes("chg_pre", LOCK_CNT + 2, 4, 2, LOCK_CNT + 1);
    gen_per  = 10;
    gen_high = 5;
    found    = 1'b0;
    for (int t = 0; t < 4; t++) begin
      wait_strobe("chg_first", 60, ok);
      if (!ok) break;
      if (period != 4) begin
        found = 1'b1;
        break;
      end
    end
    check("chg_found", {31'b0, found}, 1);
    check("chg_first_period", 32'(period), 10);
    check("chg_first_locked", {31'b0, locked}, 0);
    run_strobes("chg_post", LOCK_CNT, 10, 5, LOCK_CNT);

    // Timeout with sig_in held low, then restart.
    start_run(4, 2);
    run_strobes("tmo_pre", LOCK_CNT + 2, 4, 2, LOCK_CNT + 1);
    gen_on = 1'b0;
    n      = 0;
    found  = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_100MHz);
      n++;
      if (period_valid) n = 0;
      if (timeout) begin
        found = 1'b1;
        break;
      end
    end
    check("tmo_seen", {31'b0, found}, 1);
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_locked", {31'b0, locked}, 0);
    check("tmo_period_hold", 32'(period), 4);
    gen_on = 1'b1;
    found  = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_100MHz);
      if (!timeout) begin
        found = 1'b1;
        break;
      end
    end
    check("tmo_cleared", {31'b0, found}, 1);
    n     = 0;
    found = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_100MHz);
      n++;
      if (period_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("tmo_restart_strobe", {31'b0, found}, 1);
    check("tmo_restart_delay", n, 4);
    check("tmo_restart_period", 32'(period), 4);

    // Asynchronous reset in the middle of a period.
    start_run(4, 2);
    run_strobes("rst_pre", LOCK_CNT + 2, 4, 2, LOCK_CNT + 1);
    @(negedge clk_100MHz);
    @(posedge clk_100MHz);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_period", 32'(period), 0);
    check("midrst_high", 32'(high_time), 0);
    check("midrst_valid", {31'b0, period_valid}, 0);
    check("midrst_locked", {31'b0, locked}, 0);
    check("midrst_timeout", {31'b0, timeout}, 0);
    @(negedge clk_100MHz);
    gen_on = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    rst = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    r0     = gen_rises;
    gen_on = 1'b1;
    wait_strobe("midrst_strobe", 40, ok);
    check("midrst_rises", gen_rises - r0, 2);
    check("midrst_first_period", 32'(period), 4);

    // Enable dropped for 3 cycles after lock.
    start_run(4, 2);
    run_strobes("en_pre", LOCK_CNT + 2, 4, 2, LOCK_CNT + 1);
    en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk_100MHz);
      check($sformatf("en_low_locked_%0d", t), {31'b0, locked}, 0);
      check($sformatf("en_low_valid_%0d", t), {31'b0, period_valid}, 0);
      check($sformatf("en_low_period_%0d", t), 32'(period), 4);
    end
    en = 1'b1;
    run_strobes("en_post", LOCK_CNT + 2, 4, 2, LOCK_CNT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
